// File: rtl/writeback_scoreboard.sv
// Tracks destination registers with in-flight long-latency writes, flags RAW hazards on
// the decode operands and blocks issue on WAW or when the scoreboard is full.
module writeback_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned COUNT_WIDTH     = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_index,
  input  logic                   writeback_valid,
  input  logic [4:0]             writeback_index,
  input  logic [4:0]             source_index_1,
  input  logic [4:0]             source_index_2,
  output logic                   hazard_1,
  output logic                   hazard_2,
  output logic                   issue_accept,
  output logic                   stall,
  output logic                   full,
  output logic [COUNT_WIDTH-1:0] outstanding_count,
  output logic                   protocol_error
);

  // Bit 0 exists only so the 5-bit indices can address the vector directly; it stays 0.
  logic [31:0]            pending_q, pending_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   perr_q, perr_d;
  logic                   set, clear, wb_orphan;

  always_comb begin
    full     = (count_q == COUNT_WIDTH'(MAX_OUTSTANDING));
    // A same-cycle writeback of the operand is covered by the forwarding path.
    hazard_1 = pending_q[source_index_1] &
               ~(writeback_valid & (writeback_index == source_index_1));
    hazard_2 = pending_q[source_index_2] &
               ~(writeback_valid & (writeback_index == source_index_2));
    // Uses registered state only, so a same-cycle writeback never unblocks an issue.
    issue_accept = issue_valid & ~full & ~pending_q[issue_index];
    stall        = hazard_1 | hazard_2 | (issue_valid & ~issue_accept);

    set       = issue_accept & (issue_index != 5'd0);
    clear     = writeback_valid & pending_q[writeback_index];
    wb_orphan = writeback_valid & (writeback_index != 5'd0) & ~pending_q[writeback_index];

    pending_d = pending_q;
    count_d   = count_q;
    perr_d    = perr_q;
    if (flush) begin
      pending_d = '0;
      count_d   = '0;
    end else begin
      if (clear) pending_d[writeback_index] = 1'b0;
      if (set)   pending_d[issue_index]     = 1'b1;
      if (set && !clear) begin
        count_d = count_q + COUNT_WIDTH'(1);
      end else if (clear && !set) begin
        count_d = count_q - COUNT_WIDTH'(1);
      end
      if (wb_orphan) perr_d = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      count_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      perr_q    <= perr_d;
    end
  end

  assign outstanding_count = count_q;
  assign protocol_error    = perr_q;

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Directed scenarios plus a randomized run, checked against a set-of-pending-registers
// model whose count is a population count rather than a running counter.
module tb_writeback_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       issue_valid = 1'b0;
  logic [4:0] issue_index = '0;
  logic       writeback_valid = 1'b0;
  logic [4:0] writeback_index = '0;
  logic [4:0] source_index_1 = '0;
  logic [4:0] source_index_2 = '0;
  logic       hazard_1, hazard_2, issue_accept, stall, full, protocol_error;
  logic [2:0] outstanding_count;

  int n_chk = 0;
  int n_fail = 0;

  bit pend_m[32];
  bit perr_m;

  writeback_scoreboard #(
    .MAX_OUTSTANDING(4),
    .COUNT_WIDTH    (3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .issue_valid      (issue_valid),
    .issue_index      (issue_index),
    .writeback_valid  (writeback_valid),
    .writeback_index  (writeback_index),
    .source_index_1   (source_index_1),
    .source_index_2   (source_index_2),
    .hazard_1         (hazard_1),
    .hazard_2         (hazard_2),
    .issue_accept     (issue_accept),
    .stall            (stall),
    .full             (full),
    .outstanding_count(outstanding_count),
    .protocol_error   (protocol_error)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int cnt_m();
    int c = 0;
    for (int r = 1; r < 32; r++) c += int'(pend_m[r]);
    return c;
  endfunction

  function automatic bit hz_m(input logic [4:0] s);
    return pend_m[s] && !(writeback_valid && writeback_index == s);
  endfunction

  function automatic bit acc_m();
    return issue_valid && (cnt_m() != 4) && !pend_m[issue_index];
  endfunction

  task automatic model_clear(input bit with_perr);
    for (int r = 0; r < 32; r++) pend_m[r] = 1'b0;
    if (with_perr) perr_m = 1'b0;
  endtask

  task automatic model_edge();
    bit a, hit;
    a   = acc_m();
    hit = pend_m[writeback_index];
    if (flush) begin
      model_clear(1'b0);
    end else begin
      if (writeback_valid && writeback_index != 5'd0) begin
        if (hit) pend_m[writeback_index] = 1'b0;
        else     perr_m = 1'b1;
      end
      if (a && issue_index != 5'd0) pend_m[issue_index] = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit iv, input logic [4:0] ii, input bit wv, input logic [4:0] wi,
                       input logic [4:0] s1, input logic [4:0] s2, input bit fl);
    issue_valid = iv; issue_index = ii; writeback_valid = wv; writeback_index = wi;
    source_index_1 = s1; source_index_2 = s2; flush = fl;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    drive(1, 5'd3, 0, 5'd0, 5'd3, 5'd3, 0);
    n_chk++; if (outstanding_count !== 3'd0) begin n_fail++;
      $display("FAIL reset_count got %0d want 0", outstanding_count); end
    n_chk++; if ({full, hazard_1, hazard_2, stall, protocol_error} !== 5'b0) begin n_fail++;
      $display("FAIL reset_flags got %b want 00000",
               {full, hazard_1, hazard_2, stall, protocol_error}); end
    n_chk++; if (issue_accept !== 1'b1) begin n_fail++;
      $display("FAIL reset_accept got %b want 1", issue_accept); end
    drive(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    reset = 1'b1;
    model_clear(1'b1);
    tick();
  endtask

  task automatic test_basic();
    drive(1, 5'd5, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if (issue_accept !== 1'b1) begin n_fail++;
      $display("FAIL basic_accept got %b want 1", issue_accept); end
    tick();
    drive(0, 5'd0, 0, 5'd0, 5'd5, 5'd0, 0);
    n_chk++; if (outstanding_count !== 3'd1) begin n_fail++;
      $display("FAIL basic_count1 got %0d want 1", outstanding_count); end
    n_chk++; if ({hazard_1, stall} !== 2'b11) begin n_fail++;
      $display("FAIL basic_hazard got %b want 11", {hazard_1, stall}); end
    drive(0, 5'd0, 1, 5'd5, 5'd5, 5'd0, 0);
    n_chk++; if ({hazard_1, stall} !== 2'b00) begin n_fail++;
      $display("FAIL basic_bypass got %b want 00", {hazard_1, stall}); end
    tick();
    drive(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if (outstanding_count !== 3'd0) begin n_fail++;
      $display("FAIL basic_count0 got %0d want 0", outstanding_count); end
  endtask

  task automatic test_full();
    for (int r = 1; r <= 4; r++) begin
      drive(1, 5'(r), 0, 5'd0, 5'd0, 5'd0, 0);
      tick();
    end
    drive(1, 5'd6, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if ({full, issue_accept, stall} !== 3'b101) begin n_fail++;
      $display("FAIL full_block got %b want 101", {full, issue_accept, stall}); end
    tick();
    n_chk++; if (outstanding_count !== 3'd4) begin n_fail++;
      $display("FAIL full_count got %0d want 4", outstanding_count); end
    drive(1, 5'd6, 1, 5'd2, 5'd0, 5'd0, 0);
    n_chk++; if (issue_accept !== 1'b0) begin n_fail++;
      $display("FAIL full_wb_same_cycle got %b want 0", issue_accept); end
    tick();
    drive(1, 5'd6, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if (issue_accept !== 1'b1) begin n_fail++;
      $display("FAIL full_retry got %b want 1", issue_accept); end
    tick();
    drive(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if (outstanding_count !== 3'd4) begin n_fail++;
      $display("FAIL full_count2 got %0d want 4", outstanding_count); end
    drive(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 1);
    tick();
  endtask

  task automatic test_waw();
    drive(1, 5'd7, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    drive(1, 5'd7, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if ({issue_accept, stall} !== 2'b01) begin n_fail++;
      $display("FAIL waw_block got %b want 01", {issue_accept, stall}); end
    drive(1, 5'd7, 1, 5'd7, 5'd0, 5'd0, 0);
    n_chk++; if (issue_accept !== 1'b0) begin n_fail++;
      $display("FAIL waw_wb_same_cycle got %b want 0", issue_accept); end
    tick();
    drive(1, 5'd7, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if (issue_accept !== 1'b1) begin n_fail++;
      $display("FAIL waw_retry got %b want 1", issue_accept); end
    tick();
    drive(0, 5'd0, 0, 5'd0, 5'd7, 5'd0, 0);
    n_chk++; if ({hazard_1, outstanding_count} !== {1'b1, 3'd1}) begin n_fail++;
      $display("FAIL waw_pending got %b want 1001", {hazard_1, outstanding_count}); end
    drive(0, 5'd0, 1, 5'd7, 5'd0, 5'd0, 0);
    tick();
  endtask

  task automatic test_protocol();
    drive(0, 5'd0, 1, 5'd9, 5'd0, 5'd0, 0);
    tick();
    drive(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if ({protocol_error, outstanding_count} !== {1'b1, 3'd0}) begin n_fail++;
      $display("FAIL perr_set got %b want 1000", {protocol_error, outstanding_count}); end
    drive(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 1);
    tick();
    drive(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if (protocol_error !== 1'b1) begin n_fail++;
      $display("FAIL perr_sticky got %b want 1", protocol_error); end
  endtask

  task automatic test_flush();
    for (int r = 11; r <= 13; r++) begin
      drive(1, 5'(r), 0, 5'd0, 5'd0, 5'd0, 0);
      tick();
    end
    drive(1, 5'd10, 0, 5'd0, 5'd11, 5'd0, 1);
    n_chk++; if ({issue_accept, hazard_1, outstanding_count} !== {2'b11, 3'd3}) begin n_fail++;
      $display("FAIL flush_preflush got %b want 11011",
               {issue_accept, hazard_1, outstanding_count}); end
    tick();
    drive(0, 5'd0, 0, 5'd0, 5'd10, 5'd11, 0);
    n_chk++; if ({hazard_1, hazard_2, outstanding_count} !== 5'b0) begin n_fail++;
      $display("FAIL flush_clear got %b want 00000",
               {hazard_1, hazard_2, outstanding_count}); end
  endtask

  task automatic test_x0_and_async_reset();
    drive(1, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if ({issue_accept, hazard_1} !== 2'b10) begin n_fail++;
      $display("FAIL x0_issue got %b want 10", {issue_accept, hazard_1}); end
    tick();
    drive(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    n_chk++; if (outstanding_count !== 3'd0) begin n_fail++;
      $display("FAIL x0_count got %0d want 0", outstanding_count); end
    drive(1, 5'd5, 0, 5'd0, 5'd0, 5'd0, 0);
    tick();
    drive(0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0);
    reset = 1'b0;
    #1;
    n_chk++; if ({protocol_error, outstanding_count} !== 4'b0) begin n_fail++;
      $display("FAIL async_reset got %b want 0000", {protocol_error, outstanding_count}); end
    reset = 1'b1;
    model_clear(1'b1);
    tick();
  endtask

  task automatic test_random();
    int         plist[$];
    logic [4:0] wi;
    for (int cyc = 0; cyc < 400; cyc++) begin
      plist.delete();
      for (int r = 1; r < 32; r++) if (pend_m[r]) plist.push_back(r);
      if (plist.size() != 0 && $urandom_range(0, 3) != 0)
        wi = 5'(plist[$urandom_range(0, plist.size() - 1)]);
      else
        wi = 5'($urandom_range(0, 9));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), wi,
            5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), $urandom_range(0, 24) == 0);
      n_chk++; if (hazard_1 !== hz_m(source_index_1)) begin n_fail++;
        $display("FAIL rand_hazard_1 cyc %0d got %b want %b", cyc, hazard_1,
                 hz_m(source_index_1)); end
      n_chk++; if (hazard_2 !== hz_m(source_index_2)) begin n_fail++;
        $display("FAIL rand_hazard_2 cyc %0d got %b want %b", cyc, hazard_2,
                 hz_m(source_index_2)); end
      n_chk++; if (issue_accept !== acc_m()) begin n_fail++;
        $display("FAIL rand_accept cyc %0d got %b want %b", cyc, issue_accept, acc_m()); end
      n_chk++; if (stall !== (hz_m(source_index_1) || hz_m(source_index_2) ||
                              (issue_valid && !acc_m()))) begin n_fail++;
        $display("FAIL rand_stall cyc %0d got %b", cyc, stall); end
      n_chk++; if (full !== (cnt_m() == 4)) begin n_fail++;
        $display("FAIL rand_full cyc %0d got %b want %b", cyc, full, cnt_m() == 4); end
      n_chk++; if (outstanding_count !== 3'(cnt_m())) begin n_fail++;
        $display("FAIL rand_count cyc %0d got %0d want %0d", cyc, outstanding_count,
                 cnt_m()); end
      n_chk++; if (protocol_error !== perr_m) begin n_fail++;
        $display("FAIL rand_perr cyc %0d got %b want %b", cyc, protocol_error, perr_m); end
      tick();
    end
  endtask

  initial begin
    model_clear(1'b1);
    test_reset();
    test_basic();
    test_full();
    test_waw();
    test_protocol();
    test_flush();
    test_x0_and_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
